seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment path.
- Each cycle it drives one digit's 2-bit select into the 2-to-4 digit decoder and that digit's BCD nibble into the BCD-to-7-segment decoder.
- Holds each digit for a programmable dwell, inserts anti-ghosting blank gaps, and accepts new display values through a valid/ready port.
- Display updates are applied only at frame boundaries, so a frame never shows a mix of old and new digits (no tearing).

Parameters:
DIV, 4, dwell cycles per digit (>=1)
BLANK_CYC, 1, blank cycles between digits (0 = no gap)
CNT_W, 8, prescaler counter width; must hold max(DIV, BLANK_CYC)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset: asynchronous, active-high
en  in  1  scan enable
upd_valid  in  1  new display value offered
upd_data  in  16  four BCD nibbles; digit0 = [3:0], digit3 = [15:12]
upd_ready  out  1  controller can accept upd_data
blank_mask  in  4  bit i=1 forces digit i dark
digit_sel  out  2  digit index to the 2-to-4 decoder (bit1 = B, bit0 = A)
bcd_out  out  4  BCD nibble to the 7-segment decoder
seg_en  out  1  display drive enable
frame_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (async, immediate): state = IDLE; digit_sel = 0, bcd_out = 0, seg_en = 0, frame_done = 0, upd_ready = 1; display and pending registers = 0; pending flag = 0; counter = 0.
- All outputs are registered except upd_ready, which is combinational (= !pend_full).
- FSM states: IDLE, SCAN, BLANK.
- IDLE:
  - Outputs are zero.
  - An accepted update writes the display register directly and does not set pend_full.
  - en=1 -> SCAN next edge with digit_sel = 0, counter = 0.
- SCAN:
  - bcd_out = display[4*digit_sel +: 4].
  - seg_en = !blank_mask[digit_sel], sampled each cycle.
  - Counter runs 0..DIV-1. At DIV-1: if BLANK_CYC > 0 -> BLANK with counter = 0; else advance digit and stay in SCAN.
- BLANK:
  - seg_en = 0; digit_sel and bcd_out held.
  - Lasts BLANK_CYC cycles, then advance digit -> SCAN.
- Advance: digit_sel wraps 3 -> 0. The wrap edge is the frame boundary:
  - frame_done = 1 for exactly one cycle.
  - If pend_full: display <= pending, pend_full <= 0.
- Update handshake:
  - Transfer occurs when upd_valid && upd_ready.
  - Outside IDLE, the transfer writes pending and sets pend_full.
  - A transfer on the frame-boundary edge with the pending register previously empty goes to pending and is applied at the next boundary.
  - upd_data is ignored while upd_ready = 0; the producer must hold it.
- Frame period = 4*(DIV + BLANK_CYC) cycles.
- en deasserted in SCAN/BLANK:
  - Next edge -> IDLE, outputs zeroed, no frame_done pulse.
  - If pend_full, pending is copied to display on that same edge.
  - Re-enable always restarts at digit 0.
- Nibbles > 9 pass through unmodified; the downstream decoder defines the glyph.
- rst mid-frame aborts immediately; all state is lost, including pending data.

Optional Feature:
Macro SEG_LZS_EN enables leading-zero suppression.
- With SEG_LZS_EN defined: while scanning digit i, seg_en is additionally forced to 0 if display nibble i and every higher nibble are 0, for i = 3..1. Digit 0 is never suppressed, so 0x0000 shows "0". Suppression is computed from the display register, not from pending.
- Without SEG_LZS_EN: all digits are driven, subject only to blank_mask.

Decomposition:
- Shared package seg_pkg:
  - state enum {IDLE, SCAN, BLANK}
  - NUM_DIGITS = 4
  - DIGIT_W = 2
  - BCD_W = 4
- One natural sub-module, seg_prescaler: a counter with terminal-count output and synchronous clear, instantiated once and reused for both dwell and blank timing.

Test Plan:
- DIV=4, BLANK_CYC=1, IDLE update 0x1234, then en=1 -> bcd_out sequence 4,3,2,1 with digit_sel 0,1,2,3; each digit seg_en high 4 cycles then low 1; frame_done every 20 cycles.
- Mid-frame (digit_sel=1), offer 0x5678 -> upd_ready drops; frame 1 still shows 1234; 0x5678 appears from the first digit0 after the wrap; upd_ready returns to 1 on the wrap edge.
- blank_mask=4'b0100 -> seg_en low for the whole digit2 dwell, other digits normal; digit_sel still steps through 2.
- en dropped at digit 2, cycle 2 of dwell -> next edge: IDLE, outputs 0, no frame_done; re-enable -> starts at digit_sel=0.
- rst asserted asynchronously mid-BLANK with pending 0x9999 -> outputs 0 immediately; after release and en=1, bcd_out = 0 on all digits.
- SEG_LZS_EN defined, display 0x0045 -> digits 3,2 dark, digits 1,0 lit; display 0x0000 -> only digit 0 lit, showing 0.

Source files
------------

// File: rtl/seg_pkg.sv
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants, state encodings and helpers for the
//                seven-segment scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 2;
    localparam int BCD_W      = 4;
    localparam int DISP_W     = NUM_DIGITS * BCD_W;

    // Scan FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_BLANK = 2'd2;

    // True when digit idx is a leading zero: idx > 0 and nibble idx and
    // every higher nibble are zero. Digit 0 is never reported dark.
    function automatic logic lzs_dark(input logic [DISP_W-1:0]  disp,
                                      input logic [DIGIT_W-1:0] idx);
        logic any_nz;
        any_nz = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(idx)) && (disp[k*BCD_W +: BCD_W] != '0))
                any_nz = 1'b1;
        end
        return (idx != '0) && !any_nz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_prescaler.sv
// ============================================================================
//  Module      : seg_prescaler
//  Description : Free-running up-counter with synchronous clear and a
//                terminal-count flag. Shared between dwell and blank timing
//                by switching the terminal value.
//  Ports       : clk, rst (async, active-high)
//                i_clr     - synchronous clear to zero (wins over counting)
//                i_tc_val  - terminal count value
//                o_tc      - high while the count equals i_tc_val
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_prescaler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_tc_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = (r_cnt == i_tc_val);

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed scan controller for a 4-digit seven-segment
//                display. Dwell of DIV cycles per digit, BLANK_CYC dark cycles
//                between digits, tear-free updates applied at frame wrap.
//  Ports       : clk, rst (async, active-high)
//                en                    - scan enable
//                upd_valid/upd_data    - new display value (4 BCD nibbles)
//                upd_ready             - combinational, = !pending_full
//                blank_mask            - bit i forces digit i dark
//                digit_sel, bcd_out    - to 2-to-4 and BCD-to-7seg decoders
//                seg_en                - display drive enable
//                frame_done            - one-cycle pulse at frame wrap
//  Options     : define SEG_LZS_EN to enable leading-zero suppression
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int BLANK_CYC = 1,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    input  logic [3:0]  blank_mask,
    output logic [1:0]  digit_sel,
    output logic [3:0]  bcd_out,
    output logic        seg_en,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] c_DWELL_TC = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_BLANK_TC = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_t              r_state;
    logic [DIGIT_W-1:0]  r_digit;
    logic [DISP_W-1:0]   r_disp;
    logic [DISP_W-1:0]   r_pend;
    logic                r_pend_full;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_seg_en;
    logic                r_frame_done;

    state_t              w_state_nxt;
    logic [DIGIT_W-1:0]  w_digit_nxt;
    logic [DISP_W-1:0]   w_disp_nxt;
    logic                w_adv;
    logic                w_wrap;
    logic                w_drop;
    logic                w_xfer;
    logic                w_apply;
    logic                w_tc;
    logic                w_clr;
    logic [CNT_W-1:0]    w_tc_val;
    logic                w_lzs_dark;

    // One counter serves both phases; its terminal value follows the state.
    assign w_tc_val = (r_state == ST_BLANK) ? c_BLANK_TC : c_DWELL_TC;
    assign w_clr    = (r_state == ST_IDLE) || !en || w_tc;

    seg_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_tc_val (w_tc_val),
        .o_tc     (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_adv       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_SCAN;
                    w_digit_nxt = '0;
                end
            end
            ST_SCAN: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_digit_nxt = '0;
                end else if (w_tc) begin
                    if (BLANK_CYC > 0)
                        w_state_nxt = ST_BLANK;
                    else
                        w_adv = 1'b1;
                end
            end
            ST_BLANK: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_digit_nxt = '0;
                end else if (w_tc) begin
                    w_state_nxt = ST_SCAN;
                    w_adv       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_digit_nxt = '0;
            end
        endcase
        if (w_adv)
            w_digit_nxt = r_digit + 1'b1;
    end

    assign w_wrap    = w_adv && (r_digit == DIGIT_W'(NUM_DIGITS - 1));
    assign w_drop    = (r_state != ST_IDLE) && !en;
    assign upd_ready = !r_pend_full;
    assign w_xfer    = upd_valid && !r_pend_full;

    // Pending data lands on the frame wrap, or when scanning stops so that
    // the value is not stranded while idle.
    assign w_apply   = r_pend_full && (w_wrap || w_drop);

    assign w_disp_nxt = ((r_state == ST_IDLE) && w_xfer) ? upd_data :
                        w_apply                          ? r_pend   :
                                                           r_disp;

`ifdef SEG_LZS_EN
    assign w_lzs_dark = lzs_dark(w_disp_nxt, w_digit_nxt);
`else
    assign w_lzs_dark = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_digit      <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_bcd        <= '0;
            r_seg_en     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_digit      <= w_digit_nxt;
            r_disp       <= w_disp_nxt;
            r_frame_done <= w_wrap;

            // w_xfer implies the pending slot is empty, so it never
            // collides with w_apply.
            if ((r_state != ST_IDLE) && w_xfer) begin
                r_pend      <= upd_data;
                r_pend_full <= 1'b1;
            end else if (w_apply) begin
                r_pend_full <= 1'b0;
            end

            // Outputs are registered against the state being entered so they
            // line up with the cycle that state occupies.
            case (w_state_nxt)
                ST_SCAN: begin
                    r_bcd    <= w_disp_nxt[w_digit_nxt*BCD_W +: BCD_W];
                    r_seg_en <= !blank_mask[w_digit_nxt] && !w_lzs_dark;
                end
                ST_BLANK: begin
                    r_seg_en <= 1'b0;
                end
                default: begin
                    r_bcd    <= '0;
                    r_seg_en <= 1'b0;
                end
            endcase
        end
    end

    assign digit_sel  = r_digit;
    assign bcd_out    = r_bcd;
    assign seg_en     = r_seg_en;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Self-checking bench for seg_scan_ctrl: directed frame table,
//                hand-written corner sequences and randomized traffic checked
//                against a frame-position reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

    localparam int DIV       = 4;
    localparam int BLANK_CYC = 1;
    localparam int CNT_W     = 8;
    localparam int S         = DIV + BLANK_CYC;   // cycles per digit slot
    localparam int P         = 4 * S;             // frame period

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_ready;
    logic [3:0]  blank_mask;
    logic [1:0]  digit_sel;
    logic [3:0]  bcd_out;
    logic        seg_en;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_ready  (upd_ready),
        .blank_mask (blank_mask),
        .digit_sel  (digit_sel),
        .bcd_out    (bcd_out),
        .seg_en     (seg_en),
        .frame_done (frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position within the frame rather than an FSM.
    bit          m_run;
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pfull;
    bit          m_fd;
    logic [3:0]  m_mask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0; m_disp = '0; m_pend = '0; m_pfull = 0; m_fd = 0; m_mask = '0;
    endtask

    // Called at a rising edge, before inputs change.
    task automatic model_edge();
        bit xfer;
        xfer   = upd_valid && !m_pfull;
        m_fd   = 0;
        m_mask = blank_mask;
        if (!m_run) begin
            if (xfer) m_disp = upd_data;
            if (en) begin m_run = 1; m_t = 0; end
        end else if (!en) begin
            if (m_pfull) begin m_disp = m_pend; m_pfull = 0; end
            if (xfer) begin m_pend = upd_data; m_pfull = 1; end
            m_run = 0;
        end else begin
            m_t = (m_t + 1) % P;
            if (m_t == 0) begin
                m_fd = 1;
                if (m_pfull) begin m_disp = m_pend; m_pfull = 0; end
            end
            if (xfer) begin m_pend = upd_data; m_pfull = 1; end
        end
    endtask

    task automatic check_outputs();
        int d;
        int w;
        logic [3:0] e_bcd;
        logic e_seg;
        d = m_t / S;
        w = m_t % S;
        e_bcd = '0;
        e_seg = 1'b0;
        if (m_run) begin
            e_bcd = m_disp[4*d +: 4];
            e_seg = (w < DIV) && !m_mask[d];
`ifdef SEG_LZS_EN
            if ((d > 0) && ((m_disp >> (4*d)) == 16'h0)) e_seg = 1'b0;
`endif
        end
        chk("digit_sel",  digit_sel,  m_run ? d : 0);
        chk("bcd_out",    bcd_out,    e_bcd);
        chk("seg_en",     seg_en,     e_seg);
        chk("frame_done", frame_done, m_fd);
        chk("upd_ready",  upd_ready,  !m_pfull);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    typedef struct {
        logic        en;
        logic        valid;
        logic [15:0] data;
        logic [3:0]  mask;
        logic [1:0]  e_sel;
        logic [3:0]  e_bcd;
        logic        e_seg;
        logic        e_fd;
        logic        e_rdy;
    } vec_t;

`ifdef SEG_LZS_EN
    task automatic lzs_frame(input logic [15:0] val, input logic [3:0] exp_lit);
        logic [3:0] lit;
        en = 0; upd_valid = 0; step(); step();
        upd_valid = 1; upd_data = val; step();
        upd_valid = 0; en = 1; blank_mask = '0;
        lit = '0;
        for (int i = 0; i < P; i++) begin
            step();
            if (seg_en) lit[digit_sel] = 1'b1;
        end
        chk("lzs_lit_digits", lit, exp_lit);
    endtask
`endif

    vec_t vec[22];

    initial begin
        int bcdseq[4];
        int t;
        int cnt;
        int cnt2;
        bit seen;
        logic [3:0] orbcd;

        bcdseq[0] = 4; bcdseq[1] = 3; bcdseq[2] = 2; bcdseq[3] = 1;
        vec[0] = '{en:1'b0, valid:1'b1, data:16'h1234, mask:4'h0,
                   e_sel:2'd0, e_bcd:4'h0, e_seg:1'b0, e_fd:1'b0, e_rdy:1'b1};
        for (int c = 0; c <= P; c++) begin
            t = c % P;
            vec[c+1] = '{en:1'b1, valid:1'b0, data:16'h0, mask:4'h0,
                         e_sel:2'(t / S), e_bcd:4'(bcdseq[t / S]),
                         e_seg:((t % S) < DIV), e_fd:(c == P), e_rdy:1'b1};
        end

        rst = 1'b1; en = 0; upd_valid = 0; upd_data = '0; blank_mask = '0;
        model_reset();
        #12;
        chk("rst_digit_sel",  digit_sel,  0);
        chk("rst_bcd_out",    bcd_out,    0);
        chk("rst_seg_en",     seg_en,     0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_upd_ready",  upd_ready,  1);
        @(negedge clk);
        rst = 1'b0;

        // Directed first frame: idle update 0x1234 then scan.
        for (int i = 0; i < 22; i++) begin
            en = vec[i].en; upd_valid = vec[i].valid; upd_data = vec[i].data;
            blank_mask = vec[i].mask;
            @(posedge clk);
            model_edge();
            #1;
            chk("tbl_sel", digit_sel,  vec[i].e_sel);
            chk("tbl_bcd", bcd_out,    vec[i].e_bcd);
            chk("tbl_seg", seg_en,     vec[i].e_seg);
            chk("tbl_fd",  frame_done, vec[i].e_fd);
            chk("tbl_rdy", upd_ready,  vec[i].e_rdy);
        end
        upd_valid = 0;

        // Mid-frame update at digit 1: held until wrap.
        for (int i = 0; i < S; i++) step();
        chk("mid_at_digit1", digit_sel, 1);
        upd_valid = 1; upd_data = 16'h5678; step();
        upd_valid = 0;
        chk("mid_ready_low", upd_ready, 0);
        seen = 0;
        for (int i = 0; i < 2*P && !seen; i++) begin
            step();
            if (frame_done) seen = 1;
        end
        chk("mid_wrap_seen", seen, 1);
        chk("mid_new_digit0", bcd_out, 4'h8);
        chk("mid_ready_back", upd_ready, 1);

        // Blank mask on digit 2 for a whole frame.
        blank_mask = 4'b0100;
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < P; i++) begin
            step();
            if (digit_sel == 2) begin
                cnt++;
                if (seg_en) cnt2++;
            end
        end
        chk("mask_d2_cycles", cnt, S);
        chk("mask_d2_lit", cnt2, 0);
        blank_mask = '0;

        // Drop enable on digit 2, dwell cycle 2.
        seen = 0;
        for (int i = 0; i < 2*P && !seen; i++) begin
            if (m_t == 2*S + 2) seen = 1;
            else step();
        end
        chk("drop_reached", seen, 1);
        en = 0; step();
        chk("drop_sel", digit_sel, 0);
        chk("drop_seg", seg_en, 0);
        chk("drop_fd",  frame_done, 0);
        en = 1; step();
        chk("reen_sel", digit_sel, 0);

        // Async reset mid-BLANK with pending 0x9999.
        for (int i = 0; i < 3; i++) step();
        upd_valid = 1; upd_data = 16'h9999; step();
        upd_valid = 0;
        seen = 0;
        for (int i = 0; i < 2*P && !seen; i++) begin
            if (m_run && (m_t % S) == DIV && m_pfull) seen = 1;
            else step();
        end
        chk("blank_reached", seen, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel",   digit_sel, 0);
        chk("arst_bcd",   bcd_out, 0);
        chk("arst_seg",   seg_en, 0);
        chk("arst_ready", upd_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        orbcd = '0;
        for (int i = 0; i < P; i++) begin
            step();
            orbcd = orbcd | bcd_out;
        end
        chk("arst_bcd_zero", orbcd, 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            en        = ($urandom_range(0, 39) != 0);
            upd_valid = ($urandom_range(0, 2) == 0);
            upd_data  = 16'($urandom);
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
            step();
        end

`ifdef SEG_LZS_EN
        lzs_frame(16'h0045, 4'b0011);
        lzs_frame(16'h0000, 4'b0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
